// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline definitions for the unified-SRAM port arbiter.
// Holds the response-owner encoding, the default starvation limit and the
// fixed-priority-with-fairness grant function used by mem_port_arbiter.
package mem_port_arbiter_pkg;

    localparam int unsigned STARVE_CNT_W       = 4;
    localparam int unsigned STARVE_MAX_DEFAULT = 4;

    // Owner of the read response returning next cycle.
    typedef enum logic [1:0] {
        RESP_NONE = 2'd0,
        RESP_INST = 2'd1,
        RESP_DATA = 2'd2
    } resp_owner_e;

    // Grant vector {inst_gnt, data_gnt}. Data wins contention unless inst has
    // already lost starve_max consecutive contended cycles.
    function automatic logic [1:0] arb_grant(
        input logic                    inst_req,
        input logic                    data_req,
        input logic [STARVE_CNT_W-1:0] starve_cnt,
        input logic [STARVE_CNT_W-1:0] starve_max
    );
        logic [1:0] gnt;
        gnt = 2'b00;
        if (inst_req && data_req) begin
            gnt = (starve_cnt == starve_max) ? 2'b10 : 2'b01;
        end else if (inst_req) begin
            gnt = 2'b10;
        end else if (data_req) begin
            gnt = 2'b01;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port synchronous SRAM between instruction fetch and the
// LSU, drives the physical port from the winner, and routes the 1-cycle read
// data back to whichever requester owns the outstanding read.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   flush                      branch flush, drops an in-flight fetch response
//   inst_req/addr, inst_gnt    fetch request side (read only)
//   inst_rvalid/rdata          fetch response
//   data_req/we/addr/wdata     LSU request side (we == 0 means read)
//   data_gnt, data_rvalid/rdata LSU grant and load response
//   mem_en/we/addr/wdata/rdata SRAM port
//   stallreq_if, stallreq_ex   same-cycle stall requests for losing requesters
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_gnt,
    output logic                inst_rvalid,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_we,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_gnt,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                mem_en,
    output logic [DATA_W/8-1:0] mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                stallreq_if,
    output logic                stallreq_ex
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [STARVE_CNT_W-1:0] STARVE_LIMIT = STARVE_CNT_W'(STARVE_MAX);

    resp_owner_e             resp_owner_q, resp_owner_d;
    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    inst_cancel_q, inst_cancel_d;

    logic       inst_req_v;
    logic       data_req_v;
    logic [1:0] gnt_vec;
    logic       data_rd;

    // Requests are masked while reset is held so the SRAM port stays idle.
    assign inst_req_v = inst_req & rst_n;
    assign data_req_v = data_req & rst_n;

    assign gnt_vec  = arb_grant(inst_req_v, data_req_v, starve_cnt_q, STARVE_LIMIT);
    assign inst_gnt = gnt_vec[1];
    assign data_gnt = gnt_vec[0];
    assign data_rd  = data_gnt & (data_we == '0);

    // SRAM port mux from the granted requester.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (data_gnt) begin
            mem_en    = 1'b1;
            mem_we    = data_we;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
        end else if (inst_gnt) begin
            mem_en    = 1'b1;
            mem_addr  = inst_addr;
        end
    end

    // Next-state: response owner, starvation counter, fetch-cancel flag.
    always_comb begin
        resp_owner_d  = RESP_NONE;
        starve_cnt_d  = starve_cnt_q;
        inst_cancel_d = 1'b0;

        if (inst_gnt) begin
            resp_owner_d = RESP_INST;
        end else if (data_rd) begin
            resp_owner_d = RESP_DATA;
        end

        // Only counts cycles where inst was present and lost to data.
        if (!inst_req_v || inst_gnt) begin
            starve_cnt_d = '0;
        end else if (data_gnt && (starve_cnt_q != STARVE_LIMIT)) begin
            starve_cnt_d = starve_cnt_q + STARVE_CNT_W'(1);
        end

        // A fetch granted in the flush cycle is the new target and must not be
        // cancelled; the flag only survives a flush with no fresh fetch issued.
        inst_cancel_d = flush & (resp_owner_q == RESP_INST) & ~inst_gnt;
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_owner_q  <= RESP_NONE;
            starve_cnt_q  <= '0;
            inst_cancel_q <= 1'b0;
        end else begin
            resp_owner_q  <= resp_owner_d;
            starve_cnt_q  <= starve_cnt_d;
            inst_cancel_q <= inst_cancel_d;
        end
    end

    // Response routing; a read caught by reset never surfaces.
    assign inst_rvalid = rst_n & (resp_owner_q == RESP_INST) & ~flush & ~inst_cancel_q;
    assign data_rvalid = rst_n & (resp_owner_q == RESP_DATA);
    assign inst_rdata  = inst_rvalid ? mem_rdata : '0;
    assign data_rdata  = data_rvalid ? mem_rdata : '0;

    // Same-cycle stall requests for the losing requester.
    assign stallreq_if = inst_req & ~inst_gnt;
    assign stallreq_ex = data_req & ~data_gnt;

    logic unused_be;
    assign unused_be = (BE_W == 0);

endmodule
